// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch-stage state encodings and the NOP word,
// also used by the debug unit.
package mips_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/i_fetch_instr_mem.sv
// Instruction memory: synchronous write port for program load,
// combinational read port for fetch. Contents are not reset.
module instr_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]        rdata_c
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch stage: load/run/halt control, PC register with
// next-PC selection, and the IF/ID pipeline register.
module i_fetch
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_load_valid,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0]        i_load_data,
  input  logic                         i_load_done,
  input  logic                         i_stall,
  input  logic                         i_branch,
  input  logic [DATA_WIDTH-1:0]        i_pcbranch,
  input  logic                         i_jump,
  input  logic [DATA_WIDTH-1:0]        i_pcjump,
  input  logic                         i_halt,
  output logic [DATA_WIDTH-1:0]        o_instruccion,
  output logic [DATA_WIDTH-1:0]        o_currentpc,
  output logic [STATE_W-1:0]           o_state,
  output logic [DATA_WIDTH-1:0]        o_pc
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  fetch_state_e          state, state_next;
  logic [DATA_WIDTH-1:0] pc_next, ins_next, cpc_next;
  logic [DATA_WIDTH-1:0] pc_plus4_c, fetch_word_c;
  logic                  load_we;

  assign pc_plus4_c = o_pc + DATA_WIDTH'(4);

  instr_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_instr_mem (
    .clk     (i_clock),
    .we      (load_we),
    .waddr   (i_load_addr),
    .wdata   (i_load_data),
    .raddr   (o_pc[AW+1:2]),
    .rdata_c (fetch_word_c)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_LOAD;
    else         state <= state_next;
  end

  // Halt beats redirect, redirect beats stall; redirects flush the wrong-path fetch.
  always_comb begin
    state_next = state;
    pc_next    = o_pc;
    ins_next   = o_instruccion;
    cpc_next   = o_currentpc;
    load_we    = 1'b0;
    case (state)
      ST_LOAD: begin
        load_we = i_load_valid;
        if (i_load_done) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_halt) begin
          state_next = ST_HALT;
          ins_next   = DATA_WIDTH'(NOP);
        end else if (i_jump || i_branch) begin
          pc_next  = i_jump ? i_pcjump : i_pcbranch;
          ins_next = DATA_WIDTH'(NOP);
          cpc_next = '0;
        end else if (!i_stall) begin
          pc_next  = pc_plus4_c;
          ins_next = fetch_word_c;
          cpc_next = pc_plus4_c;
        end
      end
      ST_HALT: ;
      default: state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_pc          <= '0;
      o_instruccion <= DATA_WIDTH'(NOP);
      o_currentpc   <= '0;
    end else begin
      o_pc          <= pc_next;
      o_instruccion <= ins_next;
      o_currentpc   <= cpc_next;
    end
  end

  assign o_state = STATE_W'(state);

endmodule

// File: tb/tb_i_fetch.sv
// Self-checking bench for i_fetch: directed program-load/fetch scenarios
// followed by random traffic, all compared against a behavioural model.
module tb_i_fetch;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;

  logic          i_clock = 1'b0;
  logic          i_reset, i_load_valid, i_load_done, i_stall;
  logic          i_branch, i_jump, i_halt;
  logic [5:0]    i_load_addr;
  logic [DW-1:0] i_load_data, i_pcbranch, i_pcjump;
  logic [DW-1:0] o_instruccion, o_currentpc, o_pc;
  logic [1:0]    o_state;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int          m_state;
  logic [31:0] m_pc, m_ins, m_cpc;
  logic [31:0] m_mem [DEPTH];

  i_fetch #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_load_valid  (i_load_valid),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .i_load_done   (i_load_done),
    .i_stall       (i_stall),
    .i_branch      (i_branch),
    .i_pcbranch    (i_pcbranch),
    .i_jump        (i_jump),
    .i_pcjump      (i_pcjump),
    .i_halt        (i_halt),
    .o_instruccion (o_instruccion),
    .o_currentpc   (o_currentpc),
    .o_state       (o_state),
    .o_pc          (o_pc)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    i_reset = 1'b0; i_load_valid = 1'b0; i_load_done = 1'b0; i_stall = 1'b0;
    i_branch = 1'b0; i_jump = 1'b0; i_halt = 1'b0;
    i_load_addr = '0; i_load_data = '0; i_pcbranch = '0; i_pcjump = '0;
  endtask

  // Advance the model by the rules for one edge, clock the DUT, compare.
  task automatic tick();
    if (i_reset) begin
      m_state = 0; m_pc = 0; m_ins = 0; m_cpc = 0;
    end else begin
      case (m_state)
        0: begin
          if (i_load_valid) m_mem[int'(i_load_addr)] = i_load_data;
          if (i_load_done) m_state = 1;
        end
        1: begin
          if (i_halt) begin
            m_state = 2; m_ins = 0;
          end else if (i_jump || i_branch) begin
            m_pc  = i_jump ? i_pcjump : i_pcbranch;
            m_ins = 0; m_cpc = 0;
          end else if (!i_stall) begin
            m_ins = m_mem[(m_pc >> 2) % DEPTH];
            m_pc  = m_pc + 32'd4;
            m_cpc = m_pc;
          end
        end
        default: ;
      endcase
    end
    @(posedge i_clock);
    #1;
    check("state", {30'b0, o_state}, 32'(m_state));
    check("pc",    o_pc,             m_pc);
    check("ins",   o_instruccion,    m_ins);
    check("cpc",   o_currentpc,      m_cpc);
  endtask

  task automatic jump_to(input logic [31:0] target);
    idle(); i_jump = 1'b1; i_pcjump = target; tick(); idle();
  endtask

  initial begin
    idle();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    m_state = 0; m_pc = 0; m_ins = 0; m_cpc = 0;

    // Reset with noisy inputs
    i_reset = 1'b1; i_jump = 1'b1; i_pcjump = 32'h40; tick(); idle();
    check("rst_state", {30'b0, o_state}, 32'd0);

    // Program load: random words 4..63, then words 0..3 with done on the last write
    for (int i = 4; i < DEPTH; i++) begin
      idle(); i_load_valid = 1'b1; i_load_addr = 6'(i); i_load_data = $urandom; tick();
    end
    for (int i = 0; i < 4; i++) begin
      idle(); i_load_valid = 1'b1; i_load_addr = 6'(i);
      i_load_data = 32'h1111_1111 * 32'(i + 1);
      i_load_done = (i == 3); tick();
    end
    idle();
    check("run_state", {30'b0, o_state}, 32'd1);

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq_ins", o_instruccion, 32'h1111_1111 * 32'(i + 1));
      check("seq_cpc", o_currentpc, 32'(4 * (i + 1)));
    end

    // Stall at PC=8
    jump_to(32'd4); tick();
    check("stall_pc0", o_pc, 32'd8);
    i_stall = 1'b1; tick(); tick(); idle();
    check("stall_ins", o_instruccion, 32'h2222_2222);
    tick();
    check("resume_ins", o_instruccion, 32'h3333_3333);

    // Branch overrides stall
    jump_to(32'd8);
    i_branch = 1'b1; i_pcbranch = 32'd0; i_stall = 1'b1; tick(); idle();
    check("br_pc", o_pc, 32'd0);
    tick();
    check("br_ins", o_instruccion, 32'h1111_1111);

    // Jump beats branch
    i_jump = 1'b1; i_pcjump = 32'd12; i_branch = 1'b1; i_pcbranch = 32'd4; tick(); idle();
    check("jb_pc", o_pc, 32'd12);

    // Memory wrap and PC arithmetic wrap
    jump_to(32'd252); tick(); tick();
    check("wrap_ins", o_instruccion, 32'h1111_1111);
    check("wrap_cpc", o_currentpc, 32'd260);
    jump_to(32'hFFFF_FFFC); tick();
    check("pcwrap_pc", o_pc, 32'd0);

    // Halt wins over jump; HALT ignores everything but reset
    jump_to(32'd12);
    i_halt = 1'b1; i_jump = 1'b1; i_pcjump = 32'd40; tick(); idle();
    check("halt_state", {30'b0, o_state}, 32'd2);
    for (int i = 0; i < 6; i++) begin
      idle(); i_load_valid = 1'b1; i_load_addr = 6'(i); i_load_data = $urandom;
      i_branch = 1'(i % 2); i_jump = (i == 3); i_pcjump = 32'h80; i_stall = (i == 4);
      i_pcbranch = 32'h20; i_load_done = 1'b1; tick();
    end
    idle();
    check("halt_pc", o_pc, 32'd12);

    // Reset out of HALT; memory keeps its contents
    i_reset = 1'b1; tick(); idle();
    i_load_done = 1'b1; tick(); idle(); tick();
    check("mem_kept", o_instruccion, 32'h1111_1111);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      i_reset      = ($urandom_range(0, 127) == 0);
      i_load_valid = 1'($urandom_range(0, 1));
      i_load_addr  = 6'($urandom_range(0, DEPTH - 1));
      i_load_data  = $urandom;
      i_load_done  = ($urandom_range(0, 7) == 0);
      i_stall      = ($urandom_range(0, 3) == 0);
      i_branch     = ($urandom_range(0, 7) == 0);
      i_pcbranch   = $urandom;
      i_jump       = ($urandom_range(0, 7) == 0);
      i_pcjump     = $urandom;
      i_halt       = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
